// File: rtl/and_or_pair_decoder.sv
// ---------------------------------------------------------------------------
// and_or_pair_decoder
//
// Receive side of the AND/OR combiner. The combiner sends
// and_p1 = (a & b) + 1 and or_m1 = (a | b) - 1. This block takes those pairs
// over a valid/ready stream and removes the +1/-1 offsets. It returns the OR
// value as out_a and the AND value as out_b, which together form one valid
// preimage of the combiner. It also counts, one bit per cycle, the positions
// where a and b differ, and flags pairs that cannot have come from any a, b.
// Running counts of delivered results and erroneous results are kept.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready is high only in IDLE
//   in_and_p1, in_or_m1   offset AND / OR values from the combiner
//   out_valid / out_ready result handshake; the result is held until accepted
//   out_a, out_b          reconstructed OR value and AND value
//   out_amb               number of bits set in OR and clear in AND
//   out_err               high if some bit is set in AND but clear in OR
//   err_count             saturating count of delivered results with out_err
//   pair_count            wrapping count of delivered results
// ---------------------------------------------------------------------------
module and_or_pair_decoder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int AMB_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_and_p1,
    input  logic [WIDTH-1:0] in_or_m1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [AMB_W-1:0] out_amb,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] pair_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HOLD
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [WIDTH-1:0] r_scan;
    logic [AMB_W-1:0] r_idx;
    logic [AMB_W-1:0] r_amb;
    logic             r_err;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_pair_count;

    logic [WIDTH-1:0] w_and_v;
    logic [WIDTH-1:0] w_or_v;
    logic             w_accept;
    logic             w_deliver;
    logic             w_last;

    // Undo the combiner offsets; both wrap modulo 2^WIDTH.
    assign w_and_v   = in_and_p1 - WIDTH'(1);
    assign w_or_v    = in_or_m1 + WIDTH'(1);
    assign w_accept  = in_valid && r_in_ready;
    assign w_deliver = r_out_valid && out_ready;
    assign w_last    = (r_idx == AMB_W'(WIDTH - 1));

    // Single FSM with registered handshake outputs. r_scan holds the
    // "differs" mask (OR set, AND clear) and is shifted right once per COUNT
    // cycle, so the bit under test is always the LSB. Bits that are set in
    // AND but clear in OR are excluded from the mask and so never counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_and        <= '0;
            r_or         <= '0;
            r_scan       <= '0;
            r_idx        <= '0;
            r_amb        <= '0;
            r_err        <= 1'b0;
            r_err_count  <= '0;
            r_pair_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_and      <= w_and_v;
                        r_or       <= w_or_v;
                        r_scan     <= w_or_v & ~w_and_v;
                        r_err      <= |(w_and_v & ~w_or_v);
                        r_amb      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    r_amb  <= r_amb + AMB_W'(r_scan[0]);
                    r_scan <= r_scan >> 1;
                    r_idx  <= r_idx + AMB_W'(1);
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Counters move only on delivery; the error count sticks
                    // at all-ones rather than wrapping back to zero.
                    if (w_deliver) begin
                        r_out_valid  <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_state      <= ST_IDLE;
                        r_pair_count <= r_pair_count + CNT_W'(1);
                        if (r_err && (r_err_count != {CNT_W{1'b1}})) begin
                            r_err_count <= r_err_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_a      = r_or;
    assign out_b      = r_and;
    assign out_amb    = r_amb;
    assign out_err    = r_err;
    assign err_count  = r_err_count;
    assign pair_count = r_pair_count;

endmodule

// File: tb/tb_and_or_pair_decoder.sv
// ---------------------------------------------------------------------------
// tb_and_or_pair_decoder
//
// Bench for and_or_pair_decoder with WIDTH=8 and CNT_W=4, so that counter
// saturation and wrap can be reached in a short run. The driver pushes the
// expected result for each accepted pair into a queue. A separate monitor
// pops that queue when a result is delivered, tracks the expected counters,
// and measures the latency from acceptance to out_valid.
// ---------------------------------------------------------------------------
module tb_and_or_pair_decoder;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int AMB_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_and_p1;
    logic [WIDTH-1:0] in_or_m1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [AMB_W-1:0] out_amb;
    logic             out_err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] pair_count;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               amb;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acceptCycle = 0;
    int   mPair = 0;
    int   mErr = 0;
    logic prevValid = 1'b0;

    and_or_pair_decoder #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_and_p1(in_and_p1),
        .in_or_m1(in_or_m1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a(out_a),
        .out_b(out_b),
        .out_amb(out_amb),
        .out_err(out_err),
        .err_count(err_count),
        .pair_count(pair_count)
    );

    // 10-unit clock period with a running edge count.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison; a mismatch prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model, derived straight from the decoding rules: remove the
    // offsets, then look at each bit position of the two values.
    function automatic exp_t model(input logic [WIDTH-1:0] p1,
                                   input logic [WIDTH-1:0] m1);
        exp_t e;
        logic [WIDTH-1:0] andV;
        logic [WIDTH-1:0] orV;
        andV  = p1 - 8'd1;
        orV   = m1 + 8'd1;
        e.a   = orV;
        e.b   = andV;
        e.amb = 0;
        e.err = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (orV[i] && !andV[i]) e.amb++;
            if (andV[i] && !orV[i]) e.err = 1'b1;
        end
        return e;
    endfunction

    // Called at a negedge. Holds the pair on the input until it is accepted,
    // then returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] p1,
                                 input logic [WIDTH-1:0] m1,
                                 input bit rndReady);
        in_valid  = 1'b1;
        in_and_p1 = p1;
        in_or_m1  = m1;
        for (int n = 0; n < 200; n++) begin
            if (in_ready) begin
                sb.push_back(model(p1, m1));
                acceptCycle = cyc + 1;
                @(negedge clk);
                in_valid  = 1'b0;
                in_and_p1 = 8'($urandom_range(0, 255));
                in_or_m1  = 8'($urandom_range(0, 255));
                return;
            end
            if (rndReady) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    // Waits until every expected result has been delivered and the block
    // is back in IDLE.
    task automatic waitDone(input bit rndReady);
        for (int n = 0; n < 300; n++) begin
            if (sb.size() == 0 && in_ready) return;
            if (rndReady) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checkOutput("done_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor, sampling 2 units after each negedge so that the stimulus
    // applied at that negedge has settled.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prevValid = 1'b0;
        end else begin
            checkOutput("pair_count", 32'(pair_count), 32'(mPair));
            checkOutput("err_count", 32'(err_count), 32'(mErr));
            if (out_valid && !prevValid) begin
                checkOutput("latency", 32'(cyc - acceptCycle), 32'(WIDTH));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("out_a", 32'(out_a), 32'(e.a));
                    checkOutput("out_b", 32'(out_b), 32'(e.b));
                    checkOutput("out_amb", 32'(out_amb), 32'(e.amb));
                    checkOutput("out_err", 32'(out_err), 32'(e.err));
                    mPair = (mPair + 1) % (1 << CNT_W);
                    if (e.err && mErr < (1 << CNT_W) - 1) mErr++;
                end
            end
            prevValid = out_valid;
        end
    end

    initial begin
        logic [WIDTH-1:0] holdA;
        logic [WIDTH-1:0] holdB;
        logic [AMB_W-1:0] holdAmb;
        logic             holdErr;
        int               errBefore;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_and_p1 = '0;
        in_or_m1  = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state.
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_a", 32'(out_a), 32'd0);
        checkOutput("rst_out_b", 32'(out_b), 32'd0);
        checkOutput("rst_out_amb", 32'(out_amb), 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_counts", 32'({err_count, pair_count}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal pair: a=0x3C, b=0x0F.
        applyStimulus(8'h0D, 8'h3E, 1'b0);
        waitDone(1'b0);
        checkOutput("nominal_pair_count", 32'(pair_count), 32'd1);

        // Wrap-around cases.
        applyStimulus(8'h00, 8'hFE, 1'b0);
        waitDone(1'b0);
        applyStimulus(8'h01, 8'hFF, 1'b0);
        waitDone(1'b0);

        // Inconsistent pair bumps the error count by one.
        errBefore = int'(err_count);
        applyStimulus(8'h02, 8'hFF, 1'b0);
        waitDone(1'b0);
        checkOutput("incons_err_count", 32'(err_count), 32'(errBefore + 1));

        // Backpressure: result held, new pair offered but not taken.
        out_ready = 1'b0;
        applyStimulus(8'h11, 8'h5A, 1'b0);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        holdA     = out_a;
        holdB     = out_b;
        holdAmb   = out_amb;
        holdErr   = out_err;
        in_valid  = 1'b1;
        in_and_p1 = 8'h81;
        in_or_m1  = 8'hC2;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_stable", 32'({out_a, out_b, out_amb, out_err}),
                        32'({holdA, holdB, holdAmb, holdErr}));
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_in_ready_after", 32'(in_ready), 32'd1);
        checkOutput("bp_valid_after", 32'(out_valid), 32'd0);
        applyStimulus(8'h81, 8'hC2, 1'b0);
        waitDone(1'b0);

        // Randomized pairs with random downstream readiness.
        for (int t = 0; t < 24; t++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
            waitDone(1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);

        // Reset after three COUNT cycles abandons the transaction.
        applyStimulus(8'h0D, 8'h3E, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        mPair = 0;
        mErr  = 0;
        #1;
        checkOutput("midrst_outputs", 32'({out_a, out_b, out_amb, out_err}), 32'd0);
        checkOutput("midrst_counts", 32'({err_count, pair_count}), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (12) @(negedge clk);
        checkOutput("midrst_no_result", 32'(out_valid), 32'd0);

        // Saturation: 17 inconsistent pairs with a 4-bit counter.
        for (int t = 0; t < 17; t++) begin
            applyStimulus(8'h02, 8'hFF, 1'b0);
            waitDone(1'b0);
        end
        checkOutput("sat_err_count", 32'(err_count), 32'd15);
        checkOutput("sat_pair_count", 32'(pair_count), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("sat_err_hold", 32'(err_count), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
